csr_machine_file: RTL

//  Parametrised machine-mode CSR file for the rv32i/rv64i core; successor to the stub CSR block.

---
 rtl/csr_machine_file_if.sv | 39 +++
 rtl/csr_machine_file.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/csr_machine_file_if.sv
// ----------------------------------------------------------------------------
// csr_machine_file_if
//   Read/query and write-back bus of the machine-mode CSR file.
//   master : EX/WB side, drives strobes, addresses, write op and operand.
//   slave  : CSR file side, returns read data and the two legality flags.
// Signals
//   rd_i            read/query strobe
//   rd_addr_i       CSR address to read/query
//   rd_data_o       registered read data (one cycle after the strobe)
//   rd_illegal_rd_o addressed CSR does not exist
//   rd_illegal_wr_o addressed CSR is not writable
//   wr_i            write-back strobe
//   wr_op_i         00 WRITE, 01 SET, 10 CLEAR, 11 no-op
//   wr_addr_i       CSR address to write
//   wr_data_i       write operand
// ----------------------------------------------------------------------------
interface csr_machine_file_if #(
    parameter int XLEN = 32
) ();
    logic            rd_i;
    logic [11:0]     rd_addr_i;
    logic [XLEN-1:0] rd_data_o;
    logic            rd_illegal_rd_o;
    logic            rd_illegal_wr_o;
    logic            wr_i;
    logic [1:0]      wr_op_i;
    logic [11:0]     wr_addr_i;
    logic [XLEN-1:0] wr_data_i;

    modport master (
        output rd_i, rd_addr_i, wr_i, wr_op_i, wr_addr_i, wr_data_i,
        input  rd_data_o, rd_illegal_rd_o, rd_illegal_wr_o
    );

    modport slave (
        input  rd_i, rd_addr_i, wr_i, wr_op_i, wr_addr_i, wr_data_i,
        output rd_data_o, rd_illegal_rd_o, rd_illegal_wr_o
    );
endinterface

// File: rtl/csr_machine_file.sv
// ----------------------------------------------------------------------------
// csr_machine_file
//   Machine-mode CSR file for the rv32i/rv64i core: mstatus/misa/mtvec/
//   mscratch/mepc/mcause/mtval storage, 64-bit mcycle/minstret counters with
//   user read-only shadows, ID registers, WRITE/SET/CLEAR write-back, legality
//   decode, and trap-entry / MRET state update.
// Parameters
//   XLEN       32 or 64 (64: the *h counter CSRs do not exist)
//   HART_ID    value returned by mhartid
//   MTVEC_RST  reset value of mtvec (bits [1:0] forced to 0)
//   MISA_VAL   read-only misa value
// Ports
//   clk_i        clock, rising edge
//   reset_i      synchronous active-high reset (overrides clk_en_i)
//   clk_en_i     global enable; low freezes every register
//   bus          read/write bus (slave side)
//   instret_i    one instruction retired this cycle
//   trap_i       trap entry; trap_cause_i/trap_pc_i/trap_val_i are loaded
//   mret_i       MRET executed this cycle
//   mtvec_o      current mtvec
//   mepc_o       current mepc
//   mie_o        mstatus.MIE
//   hpl_o        privilege level, always machine (2'b11)
// ----------------------------------------------------------------------------
module csr_machine_file #(
    parameter int              XLEN      = 32,
    parameter int              HART_ID   = 0,
    parameter logic [XLEN-1:0] MTVEC_RST = '0,
    parameter logic [XLEN-1:0] MISA_VAL  = XLEN'(32'h4000_0100)
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             clk_en_i,
    csr_machine_file_if.slave bus,
    input  logic             instret_i,
    input  logic             trap_i,
    input  logic [XLEN-1:0]  trap_cause_i,
    input  logic [XLEN-1:0]  trap_pc_i,
    input  logic [XLEN-1:0]  trap_val_i,
    input  logic             mret_i,
    output logic [XLEN-1:0]  mtvec_o,
    output logic [XLEN-1:0]  mepc_o,
    output logic             mie_o,
    output logic [1:0]       hpl_o
);

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_SET   = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
    localparam logic [11:0] CSR_MVENDORID = 12'hF11;
    localparam logic [11:0] CSR_MARCHID   = 12'hF12;
    localparam logic [11:0] CSR_MIMPID    = 12'hF13;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    // mtvec and mepc are always 4-byte aligned.
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    typedef struct packed {
        logic [XLEN-1:0] data;
        logic            exists;
    } csr_rd_t;

    logic            mie_q;
    logic            mpie_q;
    logic [XLEN-1:0] mtvec_q;
    logic [XLEN-1:0] mscratch_q;
    logic [XLEN-1:0] mepc_q;
    logic [XLEN-1:0] mcause_q;
    logic [XLEN-1:0] mtval_q;
    logic [63:0]     mcycle_q;
    logic [63:0]     minstret_q;
    logic [XLEN-1:0] rd_data_q;
    logic            rd_ill_rd_q;
    logic            rd_ill_wr_q;

    logic [XLEN-1:0] mstatus_val;
    csr_rd_t         rd_look;
    csr_rd_t         wr_look;
    logic            wr_en;
    logic [XLEN-1:0] wr_new;

    // Current architectural value of a CSR, and whether the address exists.
    // Shared by the read port and the read-modify-write of the write port.
    function automatic csr_rd_t csr_lookup(input logic [11:0] addr);
        csr_rd_t r;
        r.data   = '0;
        r.exists = 1'b1;
        case (addr)
            CSR_MSTATUS:               r.data = mstatus_val;
            CSR_MISA:                  r.data = MISA_VAL;
            CSR_MTVEC:                 r.data = mtvec_q;
            CSR_MSCRATCH:              r.data = mscratch_q;
            CSR_MEPC:                  r.data = mepc_q;
            CSR_MCAUSE:                r.data = mcause_q;
            CSR_MTVAL:                 r.data = mtval_q;
            CSR_MCYCLE, CSR_CYCLE:     r.data = mcycle_q[XLEN-1:0];
            CSR_MINSTRET, CSR_INSTRET: r.data = minstret_q[XLEN-1:0];
            CSR_MCYCLEH, CSR_CYCLEH: begin
                if (XLEN == 32) r.data[31:0] = mcycle_q[63:32];
                else            r.exists     = 1'b0;
            end
            CSR_MINSTRETH, CSR_INSTRETH: begin
                if (XLEN == 32) r.data[31:0] = minstret_q[63:32];
                else            r.exists     = 1'b0;
            end
            CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID: r.data = '0;
            CSR_MHARTID:               r.data = XLEN'(HART_ID);
            default:                   r.exists = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic wr_hit(input logic [11:0] addr);
        return wr_en && (bus.wr_addr_i == addr);
    endfunction

    // NOTE: every combinational output gets a default first, so no path through
    // the block leaves a variable unassigned and no latch is inferred.
    always_comb begin
        mstatus_val        = '0;
        mstatus_val[12:11] = 2'b11;           // MPP: only M-mode exists
        mstatus_val[7]     = mpie_q;
        mstatus_val[3]     = mie_q;

        rd_look = csr_lookup(bus.rd_addr_i);
        wr_look = csr_lookup(bus.wr_addr_i);

        // Writes to the read-only space (addr[11:10]==11), to unknown
        // addresses and with the reserved op are dropped silently. misa exists
        // and is writable-space but has no storage, so it ignores writes too.
        wr_en = clk_en_i && bus.wr_i && wr_look.exists
                && (bus.wr_addr_i[11:10] != 2'b11) && (bus.wr_op_i != OP_RSVD);

        case (bus.wr_op_i)
            OP_SET:   wr_new = wr_look.data | bus.wr_data_i;
            OP_CLEAR: wr_new = wr_look.data & ~bus.wr_data_i;
            default:  wr_new = bus.wr_data_i;   // OP_WRITE (OP_RSVD is gated by wr_en)
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values; this is what makes a same-cycle read
    // of a CSR being written return the old value.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rd_data_q   <= '0;
            rd_ill_rd_q <= 1'b0;
            rd_ill_wr_q <= 1'b0;
            mie_q       <= 1'b0;
            mpie_q      <= 1'b0;
            mtvec_q     <= MTVEC_RST & ALIGN_MASK;
            mscratch_q  <= '0;
            mepc_q      <= '0;
            mcause_q    <= '0;
            mtval_q     <= '0;
            mcycle_q    <= '0;
            minstret_q  <= '0;
        end else if (clk_en_i) begin
            if (bus.rd_i) begin
                rd_data_q   <= rd_look.data;
                rd_ill_rd_q <= !rd_look.exists;
                rd_ill_wr_q <= !rd_look.exists || (bus.rd_addr_i[11:10] == 2'b11);
            end

            // mstatus: trap > mret > CSR write
            if (trap_i) begin
                mpie_q <= mie_q;
                mie_q  <= 1'b0;
            end else if (mret_i) begin
                mie_q  <= mpie_q;
                mpie_q <= 1'b1;
            end else if (wr_hit(CSR_MSTATUS)) begin
                mie_q  <= wr_new[3];
                mpie_q <= wr_new[7];
            end

            if (wr_hit(CSR_MTVEC))    mtvec_q    <= wr_new & ALIGN_MASK;
            if (wr_hit(CSR_MSCRATCH)) mscratch_q <= wr_new;

            if (trap_i)                   mepc_q <= trap_pc_i & ALIGN_MASK;
            else if (wr_hit(CSR_MEPC))    mepc_q <= wr_new & ALIGN_MASK;

            if (trap_i)                   mcause_q <= trap_cause_i;
            else if (wr_hit(CSR_MCAUSE))  mcause_q <= wr_new;

            if (trap_i)                   mtval_q <= trap_val_i;
            else if (wr_hit(CSR_MTVAL))   mtval_q <= wr_new;

            // A write to either half replaces the increment for that cycle;
            // the untouched half keeps its value, no carry is propagated.
            if (wr_hit(CSR_MCYCLE)) begin
                if (XLEN == 32) mcycle_q[31:0] <= wr_new[31:0];
                else            mcycle_q       <= 64'(wr_new);
            end else if (wr_hit(CSR_MCYCLEH)) begin
                mcycle_q[63:32] <= wr_new[31:0];
            end else begin
                mcycle_q <= mcycle_q + 64'd1;
            end

            if (wr_hit(CSR_MINSTRET)) begin
                if (XLEN == 32) minstret_q[31:0] <= wr_new[31:0];
                else            minstret_q       <= 64'(wr_new);
            end else if (wr_hit(CSR_MINSTRETH)) begin
                minstret_q[63:32] <= wr_new[31:0];
            end else if (instret_i) begin
                minstret_q <= minstret_q + 64'd1;
            end
        end
    end

    assign bus.rd_data_o       = rd_data_q;
    assign bus.rd_illegal_rd_o = rd_ill_rd_q;
    assign bus.rd_illegal_wr_o = rd_ill_wr_q;

    assign mtvec_o = mtvec_q;
    assign mepc_o  = mepc_q;
    assign mie_o   = mie_q;
    assign hpl_o   = 2'b11;

endmodule
